// File: rtl/prog_loader.sv
// prog_loader: assembles little-endian byte pairs into INSTR_W-bit instructions, writes them to
// instruction memory and holds the core in reset until done. Define PROG_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module prog_loader #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 9
) (
  input  logic               CLK,
  input  logic               Init,
  input  logic               Start,
  input  logic [ADDR_W-1:0]  Length,
  input  logic               In_valid,
  input  logic [7:0]         In_data,
  output logic               In_ready,
  output logic               Wr_en,
  output logic [ADDR_W-1:0]  Wr_addr,
  output logic [INSTR_W-1:0] Wr_data,
  output logic               Core_hold,
  output logic               Done,
  output logic               Error
);

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_CSUM, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;
`endif

  state_t             r_state, w_next;
  logic [ADDR_W-1:0]  r_len, r_cnt, w_cnt_inc;
  logic [7:0]         r_lo;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [INSTR_W-1:0] r_wr_data;
  logic               w_xfer, w_start, w_last, w_in_lo, w_in_hi;

`ifdef PROG_LOADER_CHECKSUM_EN
  assign In_ready = (r_state == S_LO) || (r_state == S_HI) || (r_state == S_CSUM);
`else
  assign In_ready = (r_state == S_LO) || (r_state == S_HI);
`endif

  assign w_xfer    = In_valid && In_ready;
  assign w_in_lo   = (r_state == S_LO);
  assign w_in_hi   = (r_state == S_HI);
  assign w_start   = Start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_cnt_inc = r_cnt + ADDR_W'(1);
  // Length of 0 wraps naturally: the incremented counter returns to 0 after 2^ADDR_W words.
  assign w_last    = (w_cnt_inc == r_len);

  assign Wr_en     = r_wr_en;
  assign Wr_addr   = r_wr_addr;
  assign Wr_data   = r_wr_data;
  assign Done      = (r_state == S_DONE);
  assign Core_hold = (r_state != S_DONE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (Start) w_next = S_LO;
      S_LO:           if (w_xfer) w_next = S_HI;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_HI:           if (w_xfer) w_next = w_last ? S_CSUM : S_LO;
      S_CSUM:         if (w_xfer) w_next = S_DONE;
`else
      S_HI:           if (w_xfer) w_next = w_last ? S_DONE : S_LO;
`endif
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Init) begin
    if (Init) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_cnt     <= '0;
      r_lo      <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_next;
      r_wr_en <= 1'b0;
      if (w_start) begin
        r_len <= Length;
        r_cnt <= '0;
      end
      if (w_in_lo && w_xfer) r_lo <= In_data;
      if (w_in_hi && w_xfer) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_cnt;
        r_wr_data <= {In_data[INSTR_W-9:0], r_lo};
        r_cnt     <= w_cnt_inc;
      end
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
  logic       r_err;

  always_ff @(posedge CLK or posedge Init) begin
    if (Init) begin
      r_csum <= '0;
      r_err  <= 1'b0;
    end else if (w_start) begin
      r_csum <= '0;
      r_err  <= 1'b0;
    end else if (w_xfer && (w_in_lo || w_in_hi)) begin
      r_csum <= r_csum ^ In_data;
    end else if (w_xfer && (r_state == S_CSUM)) begin
      r_err <= (In_data != r_csum);
    end
  end

  assign Error = r_err;
`else
  assign Error = 1'b0;
`endif

endmodule
